// File: rtl/wisc_pkg.sv
// Shared ALU opcode, branch-condition and flag-index definitions for the WISC
// execute stage, plus the flag-register update rule.
package wisc_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_NAND = 3'b010,
    OP_XOR  = 3'b011,
    OP_INC  = 3'b100,
    OP_SRA  = 3'b101,
    OP_SRL  = 3'b110,
    OP_SLL  = 3'b111
  } alu_op_e;

  typedef enum logic [2:0] {
    CC_NEQ    = 3'b000,
    CC_EQ     = 3'b001,
    CC_GT     = 3'b010,
    CC_LT     = 3'b011,
    CC_GTE    = 3'b100,
    CC_LTE    = 3'b101,
    CC_OVFL   = 3'b110,
    CC_UNCOND = 3'b111
  } cond_e;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  // Arithmetic ops own all three flags, logic ops only Z, shifts none.
  function automatic logic [2:0] next_flags(alu_op_e op, logic [2:0] cur,
                                            logic [2:0] alu_flags);
    logic [2:0] nf;
    nf = cur;
    case (op)
      OP_ADD, OP_SUB, OP_INC: nf = alu_flags;
      OP_NAND, OP_XOR: begin
        nf         = 3'b000;
        nf[FLAG_Z] = alu_flags[FLAG_Z];
      end
      default: nf = cur;
    endcase
    return nf;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch resolver: evaluates a condition code against Z/V/N.
module branch_cond
  import wisc_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       taken
);

  logic w_z, w_v, w_n;

  assign w_z = flags[FLAG_Z];
  assign w_v = flags[FLAG_V];
  assign w_n = flags[FLAG_N];

  always_comb begin
    // NOTE: combinational outputs get a default first so no path infers a latch.
    taken = 1'b0;
    case (cond_e'(cond))
      CC_NEQ:    taken = !w_z;
      CC_EQ:     taken = w_z;
      CC_GT:     taken = !w_z && !w_n;
      CC_LT:     taken = w_n;
      CC_GTE:    taken = !w_n;
      CC_LTE:    taken = w_n || w_z;
      CC_OVFL:   taken = w_v;
      CC_UNCOND: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_capture.sv
// Execute-stage capture: 2-entry skid buffer between the ALU and writeback that
// also owns the architectural flag register and resolves branches on entry.
module ex_capture
  import wisc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_control,
  input  logic [DATA_W-1:0] in_result,
  input  logic [2:0]        in_flags,
  input  logic              in_is_branch,
  input  logic [2:0]        in_cond,
  input  logic [REG_W-1:0]  in_dst,
  input  logic              in_wr_en,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_W-1:0]  out_dst,
  output logic              out_wr_en,
  output logic              out_taken,
  output logic [2:0]        flag_reg
);

  logic              r_out_valid, r_skid_valid, r_in_ready;
  logic [DATA_W-1:0] r_out_result, r_skid_result;
  logic [REG_W-1:0]  r_out_dst, r_skid_dst;
  logic              r_out_wr_en, r_skid_wr_en;
  logic              r_out_taken, r_skid_taken;
  logic [2:0]        r_flag;

  logic w_in_fire, w_out_free, w_br_taken, w_taken, w_wr_en;
  logic w_out_valid_nxt, w_skid_valid_nxt;
  logic w_out_from_skid, w_out_from_in, w_load_skid;

  assign w_in_fire  = in_valid && r_in_ready;
  assign w_out_free = !r_out_valid || out_ready;

  // Branches see the flags as left by every earlier accepted entry.
  branch_cond u_branch_cond (
    .cond  (in_cond),
    .flags (r_flag),
    .taken (w_br_taken)
  );

  assign w_taken = in_is_branch && w_br_taken;
  assign w_wr_en = in_wr_en && !in_is_branch;

  always_comb begin
    w_out_valid_nxt  = r_out_valid;
    w_skid_valid_nxt = r_skid_valid;
    w_out_from_skid  = 1'b0;
    w_out_from_in    = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_out_valid_nxt  = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        // in_ready is low whenever skid is full, so no input competes here.
        w_out_from_skid  = 1'b1;
        w_out_valid_nxt  = 1'b1;
        w_skid_valid_nxt = 1'b0;
      end else begin
        w_out_from_in   = w_in_fire;
        w_out_valid_nxt = w_in_fire;
      end
    end else if (w_in_fire) begin
      w_load_skid      = 1'b1;
      w_skid_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      r_out_valid  <= w_out_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag <= 3'b000;
    end else if (w_in_fire && !flush && !in_is_branch) begin
      r_flag <= next_flags(alu_op_e'(in_control), r_flag, in_flags);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_result <= '0;
      r_out_dst    <= '0;
      r_out_wr_en  <= 1'b0;
      r_out_taken  <= 1'b0;
    end else if (w_out_from_skid) begin
      r_out_result <= r_skid_result;
      r_out_dst    <= r_skid_dst;
      r_out_wr_en  <= r_skid_wr_en;
      r_out_taken  <= r_skid_taken;
    end else if (w_out_from_in) begin
      r_out_result <= in_result;
      r_out_dst    <= in_dst;
      r_out_wr_en  <= w_wr_en;
      r_out_taken  <= w_taken;
    end
  end

  // NOTE: skid payload has no reset; r_skid_valid alone qualifies it.
  always_ff @(posedge clk) begin
    if (w_load_skid) begin
      r_skid_result <= in_result;
      r_skid_dst    <= in_dst;
      r_skid_wr_en  <= w_wr_en;
      r_skid_taken  <= w_taken;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_dst    = r_out_dst;
  assign out_wr_en  = r_out_wr_en;
  assign out_taken  = r_out_taken;
  assign flag_reg   = r_flag;

endmodule

// File: tb/tb_ex_capture.sv
// Self-checking bench for ex_capture: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_ex_capture;

  localparam int DW = 16;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [2:0]    in_control;
  logic [DW-1:0] in_result;
  logic [2:0]    in_flags;
  logic          in_is_branch;
  logic [2:0]    in_cond;
  logic [RW-1:0] in_dst;
  logic          in_wr_en;
  logic          flush;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_result;
  logic [RW-1:0] out_dst;
  logic          out_wr_en, out_taken;
  logic [2:0]    flag_reg;

  ex_capture #(.DATA_W(DW), .REG_W(RW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_control   (in_control),
    .in_result    (in_result),
    .in_flags     (in_flags),
    .in_is_branch (in_is_branch),
    .in_cond      (in_cond),
    .in_dst       (in_dst),
    .in_wr_en     (in_wr_en),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_dst      (out_dst),
    .out_wr_en    (out_wr_en),
    .out_taken    (out_taken),
    .flag_reg     (flag_reg)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, XOR = 3'b011,
                         INC = 3'b100, SLL = 3'b111;
  localparam logic [2:0] C_EQ = 3'b001, C_OVFL = 3'b110;

  typedef struct packed {
    logic [DW-1:0] result;
    logic [RW-1:0] dst;
    logic          wr;
    logic          taken;
  } ent_t;

  ent_t       q[$];
  logic [2:0] m_flags;
  logic       m_ready;
  logic       m_in_rst;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Flag register: arithmetic ops take all of Z/V/N, logic ops keep only Z, shifts leave it.
  function automatic logic [2:0] ref_flags(logic [2:0] op, logic [2:0] f, logic [2:0] cur);
    if (op == ADD || op == SUB || op == INC) return f;
    if (op == 3'b010 || op == XOR) return {f[2], 2'b00};
    return cur;
  endfunction

  function automatic logic ref_taken(logic [2:0] c, logic [2:0] f);
    logic z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic reset_model();
    q.delete();
    m_flags  = 3'b000;
    m_ready  = 1'b0;
    m_in_rst = 1'b1;
  endtask

  task automatic compare(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    check({tag, ".in_ready"}, 32'(in_ready), 32'(m_ready));
    check({tag, ".flag_reg"}, 32'(flag_reg), 32'(m_flags));
    if (q.size() > 0) begin
      check({tag, ".out_result"}, 32'(out_result), 32'(q[0].result));
      check({tag, ".out_dst"}, 32'(out_dst), 32'(q[0].dst));
      check({tag, ".out_wr_en"}, 32'(out_wr_en), 32'(q[0].wr));
      check({tag, ".out_taken"}, 32'(out_taken), 32'(q[0].taken));
    end else if (m_in_rst) begin
      check({tag, ".rst_payload"}, 32'({out_result, out_dst, out_wr_en, out_taken}), 32'(0));
    end
  endtask

  // Advance the model by one clock edge using the inputs as currently driven, then compare.
  task automatic tick(input string tag);
    ent_t e;
    bit   fi, fo;
    if (!rst_n) begin
      reset_model();
    end else begin
      fi = in_valid && m_ready;
      fo = (q.size() > 0) && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (fo) void'(q.pop_front());
        if (fi) begin
          e.result = in_result;
          e.dst    = in_dst;
          e.wr     = in_wr_en && !in_is_branch;
          e.taken  = in_is_branch && ref_taken(in_cond, m_flags);
          q.push_back(e);
          if (!in_is_branch) m_flags = ref_flags(in_control, in_flags, m_flags);
        end
      end
      m_ready  = q.size() < 2;
      m_in_rst = 1'b0;
    end
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic set_alu(input logic [2:0] op, input logic [DW-1:0] res,
                         input logic [2:0] f, input logic [RW-1:0] dst);
    in_valid     = 1'b1;
    in_control   = op;
    in_result    = res;
    in_flags     = f;
    in_is_branch = 1'b0;
    in_cond      = 3'b000;
    in_dst       = dst;
    in_wr_en     = 1'b1;
  endtask

  task automatic set_branch(input logic [2:0] c);
    in_valid     = 1'b1;
    in_control   = SUB;
    in_result    = 16'h00B0 + 16'(c);
    in_flags     = 3'b111;
    in_is_branch = 1'b1;
    in_cond      = c;
    in_dst       = 4'hF;
    in_wr_en     = 1'b1;
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    reset_model();
    compare("rst_async");
    check("rst_async.out_valid_zero", 32'(out_valid), 32'(0));
    check("rst_async.in_ready_zero", 32'(in_ready), 32'(0));
    tick("rst_hold");
    rst_n = 1'b1;
    #1;
    compare("rst_release");
    tick("rst_ready_rise");
    check("rst_ready_rise.in_ready_one", 32'(in_ready), 32'(1));
  endtask

  initial begin
    logic [2:0] saved_flags;
    rst_n = 1'b1;
    in_valid = 1'b0; in_control = 3'b000; in_result = '0; in_flags = 3'b000;
    in_is_branch = 1'b0; in_cond = 3'b000; in_dst = '0; in_wr_en = 1'b0;
    flush = 1'b0; out_ready = 1'b1;
    reset_model();

    #2 rst_n = 1'b0;
    #1;
    compare("init_rst");
    tick("init_rst_hold");
    rst_n = 1'b1;
    #1;
    compare("init_release");
    tick("init_ready_rise");

    // ADD result 0 with Z set; one-cycle latency
    set_alu(ADD, 16'h0000, 3'b100, 4'h1);
    tick("add");
    check("add.valid_n1", 32'(out_valid), 32'(1));
    check("add.flag_100", 32'(flag_reg), 32'(3'b100));
    in_valid = 1'b0;

    // XOR keeps Z only, shifts leave flags alone
    set_alu(XOR, 16'h8001, 3'b011, 4'h2);
    tick("xor");
    check("xor.flag_000", 32'(flag_reg), 32'(3'b000));
    set_alu(SLL, 16'h0002, 3'b111, 4'h3);
    tick("sll");
    check("sll.flag_000", 32'(flag_reg), 32'(3'b000));

    // SUB overflow then branches resolved against it
    set_alu(SUB, 16'h7FFF, 3'b010, 4'h4);
    tick("sub");
    set_branch(C_OVFL);
    tick("br_ovfl");
    check("br_ovfl.taken", 32'(out_taken), 32'(1));
    set_branch(C_EQ);
    tick("br_eq");
    check("br_eq.taken", 32'(out_taken), 32'(0));
    check("br_eq.wr_en", 32'(out_wr_en), 32'(0));
    in_valid = 1'b0;
    tick("drain0");

    // Stall: three offered, two accepted, then ordered release
    out_ready = 1'b0;
    set_alu(ADD, 16'hA000, 3'b100, 4'h5);
    tick("stall_0");
    set_alu(ADD, 16'hA001, 3'b100, 4'h6);
    tick("stall_1");
    check("stall_1.in_ready_low", 32'(in_ready), 32'(0));
    set_alu(ADD, 16'hA002, 3'b000, 4'h7);
    tick("stall_2");
    check("stall_2.hold_result", 32'(out_result), 32'(16'hA000));
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick("release_0");
    check("release_0.result", 32'(out_result), 32'(16'hA001));
    tick("release_1");
    check("release_1.empty", 32'(out_valid), 32'(0));

    // Flush with both entries full and an INC offered
    out_ready = 1'b0;
    set_alu(ADD, 16'hB000, 3'b100, 4'h8);
    tick("fill_0");
    set_alu(ADD, 16'hB001, 3'b100, 4'h9);
    tick("fill_1");
    saved_flags = m_flags;
    set_alu(INC, 16'hB002, 3'b001, 4'hA);
    flush = 1'b1;
    tick("flush_full");
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_full.out_valid", 32'(out_valid), 32'(0));
    check("flush_full.in_ready", 32'(in_ready), 32'(1));
    check("flush_full.flags", 32'(flag_reg), 32'(saved_flags));

    // Flush while an input is actually accepted: entry and its flags dropped
    set_alu(ADD, 16'hC000, 3'b100, 4'hB);
    tick("fill_c");
    saved_flags = m_flags;
    set_alu(INC, 16'hC001, 3'b001, 4'hC);
    flush = 1'b1;
    tick("flush_accept");
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_accept.flags", 32'(flag_reg), 32'(saved_flags));
    check("flush_accept.out_valid", 32'(out_valid), 32'(0));
    out_ready = 1'b1;

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    set_alu(ADD, 16'hD000, 3'b100, 4'hD);
    tick("pre_rst_0");
    set_alu(XOR, 16'hD001, 3'b000, 4'hE);
    tick("pre_rst_1");
    in_valid = 1'b0;
    do_reset();
    out_ready = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      out_ready    = ($urandom_range(0, 2) != 0);
      flush        = ($urandom_range(0, 19) == 0);
      in_control   = 3'($urandom);
      in_result    = 16'($urandom);
      in_flags     = 3'($urandom);
      in_is_branch = ($urandom_range(0, 2) == 0);
      in_cond      = 3'($urandom);
      in_dst       = 4'($urandom);
      in_wr_en     = 1'($urandom);
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_capture.md
EX_CAPTURE -- requirements
Module: ex_capture

Interface
REQ-001 The parameter list SHALL contain: DATA_W, default 16, datapath width; REG_W, default 4, destination register index width.
REQ-002 The port list SHALL be as follows; clock and reset come first:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  upstream ALU result valid.
- in_ready  output  1  ex_capture can accept this cycle.
- in_control  input  3  ALU opcode: ADD=000, SUB=001, NAND=010, XOR=011, INC=100, SRA=101, SRL=110, SLL=111.
- in_result  input  DATA_W  ALU result.
- in_flags  input  3  ALU flags: [2]=Z, [1]=V, [0]=N.
- in_is_branch  input  1  entry is a conditional branch, not an ALU writeback.
- in_cond  input  3  branch condition: NEQ=000, EQ=001, GT=010, LT=011, GTE=100, LTE=101, OVFL=110, UNCOND=111.
- in_dst  input  REG_W  destination register.
- in_wr_en  input  1  entry writes register file.
- flush  input  1  discard all buffered entries.
- out_valid  output  1  downstream entry valid.
- out_ready  input  1  downstream accepts.
- out_result  output  DATA_W  captured result.
- out_dst  output  REG_W  captured destination.
- out_wr_en  output  1  captured write enable, forced 0 for branches.
- out_taken  output  1  branch resolved taken, 0 for non-branches.
- flag_reg  output  3  architectural Z/V/N register.

Function
REQ-003 A transfer SHALL occur on the input when in_valid and in_ready are both 1, and on the output when out_valid and out_ready are both 1.
REQ-004 Buffering SHALL be 2 entries (output register plus skid register); in_ready SHALL be registered and equal to "skid entry empty".
REQ-005 Latency SHALL be 1 cycle: an entry accepted in cycle N with the output stage empty or draining SHALL present out_valid=1 in cycle N+1.
REQ-006 If the output stage holds a stalled entry (out_valid=1, out_ready=0) on acceptance, the new entry SHALL go to skid and in_ready SHALL be 0 the next cycle.
REQ-007 When the output drains and skid is occupied, the skid entry SHALL move to the output stage the same edge, and in_ready SHALL return to 1 the following cycle.
REQ-008 Order SHALL be preserved; out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-009 flag_reg SHALL update on input acceptance of non-branch entries only:
- ADD/SUB/INC: Z, V, N all take in_flags.
- NAND/XOR: Z takes in_flags[2]; V and N are forced 0.
- SRA/SRL/SLL: unchanged.
REQ-010 Branch entries SHALL resolve at acceptance against current flag_reg, which reflects all previously accepted entries:
- NEQ: !Z; EQ: Z; GT: !Z&!N; LT: N; GTE: !N; LTE: N|Z; OVFL: V; UNCOND: 1.
- The result SHALL be stored with the entry as out_taken.
REQ-011 flush=1 SHALL clear both entries (out_valid=0, in_ready=1 next cycle). An input accepted in the same cycle SHALL be discarded and SHALL NOT update flag_reg. flag_reg SHALL retain updates from earlier accepted entries.
REQ-012 Simultaneous output drain and input accept with an empty skid SHALL load the new entry directly into the output stage with no bubble.

Reset
REQ-013 While rst_n=0, the following SHALL be forced asynchronously: out_valid=0, in_ready=0, flag_reg=000, out_result=0, out_dst=0, out_wr_en=0, out_taken=0, skid empty.
REQ-014 in_ready SHALL rise to 1 on the first clk edge after rst_n deasserts. Reset mid-stall SHALL drop all buffered entries.

Structure
REQ-015 Shared package wisc_pkg SHALL hold the opcode constants, condition-code constants, and flag bit indices (FLAG_Z=2, FLAG_V=1, FLAG_N=0).
REQ-016 Branch evaluation SHALL be a combinational sub-module branch_cond (inputs cond and flags; output taken); buffering and flag logic SHALL stay in ex_capture.

Verification
REQ-017 Scenario: after reset, accept ADD with result 0x0000, flags 100; out_ready=1 -> next cycle out_valid=1, out_result=0x0000, flag_reg=100.
REQ-018 Scenario: XOR with in_flags=011 and result 0x8001 -> flag_reg=000; then SLL with in_flags=111 -> flag_reg still 000.
REQ-019 Scenario: SUB 0x8000-0x0001 with flags 010, followed by branch OVFL -> out_taken=1; a following branch EQ -> out_taken=0 with out_wr_en=0.
REQ-020 Scenario: hold out_ready=0 and offer 3 back-to-back entries -> 2 accepted, in_ready=0 from the 3rd cycle; release out_ready -> entries exit in order, one per cycle, no loss or duplication.
REQ-021 Scenario: flush with both entries full and in_valid=1 carrying INC flags 001 -> next cycle out_valid=0, in_ready=1, flag_reg unchanged.
REQ-022 Scenario: assert rst_n=0 mid-stall between edges -> outputs clear immediately, without waiting for a clk edge.
